// File: rtl/pack_queue_fifo_pkg.sv
// pack_queue_fifo_pkg: default widths and the ratio helpers shared by the packing queue
package pack_queue_fifo_pkg;
    localparam int DEF_IN_WIDTH  = 32;
    localparam int DEF_OUT_WIDTH = 512;

    function automatic int ratio_f(input int out_w, input int in_w);
        return out_w / in_w;
    endfunction

    function automatic int cnt_bits_f(input int out_w, input int in_w);
        return $clog2(out_w / in_w);
    endfunction

    function automatic bit width_ok_f(input int out_w, input int in_w);
        int r = out_w / in_w;
        return (out_w % in_w == 0) && (r >= 2) && ((r & (r - 1)) == 0);
    endfunction
endpackage

// File: rtl/pack_queue_fifo_pack_stage.sv
// pack_queue_fifo_pack_stage: gathers narrow beats into a wide word and strobes whole words out
module pack_queue_fifo_pack_stage
    import pack_queue_fifo_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  d_a,
    input  logic                 vld_a,
    input  logic                 flush,
    input  logic                 full,
    output logic                 rdy_a,
    output logic                 accept,
    output logic                 wr_en,
    output logic [OUT_WIDTH-1:0] wr_data
);
    localparam int RATIO = ratio_f(OUT_WIDTH, IN_WIDTH);
    localparam int CW    = cnt_bits_f(OUT_WIDTH, IN_WIDTH);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] part_q, part_d, beat_w;
    logic                 pend_q, pend_d, last;

    assign last    = cnt_q == CW'(RATIO - 1);
    assign rdy_a   = !reset && !pend_q && (!last || !full);
    assign accept  = vld_a && rdy_a;
    assign beat_w  = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, d_a} << (IN_WIDTH * int'(cnt_q));
    assign wr_data = accept ? (part_q | beat_w) : part_q;

    // a parked flush owns the next free slot; otherwise completion beats a flush
    always_comb begin
        cnt_d  = cnt_q;
        part_d = part_q;
        pend_d = pend_q;
        wr_en  = 1'b0;
        if (pend_q) begin
            if (!full) begin
                wr_en  = 1'b1;
                cnt_d  = '0;
                part_d = '0;
                pend_d = 1'b0;
            end
        end else if (accept && last) begin
            wr_en  = 1'b1;
            cnt_d  = '0;
            part_d = '0;
        end else if (flush && (cnt_q != '0 || accept)) begin
            if (!full) begin
                wr_en  = 1'b1;
                cnt_d  = '0;
                part_d = '0;
            end else begin
                pend_d = 1'b1;
                part_d = wr_data;
                cnt_d  = cnt_q + CW'(accept);
            end
        end else if (accept) begin
            part_d = wr_data;
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            part_q <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            part_q <= part_d;
            pend_q <= pend_d;
        end
    end
endmodule

// File: rtl/pack_queue_fifo.sv
// pack_queue_fifo: narrow-to-wide packer feeding a first-word-fall-through word FIFO with profiling counters
module pack_queue_fifo
    import pack_queue_fifo_pkg::*;
#(
    parameter int PAYLOAD_BITS = 32,
    parameter int IN_WIDTH     = DEF_IN_WIDTH,
    parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
    parameter int ASIZE        = 5,
    parameter int INPUT_PORT   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IN_WIDTH-1:0]     d_a,
    input  logic                    vld_a,
    output logic                    rdy_a,
    input  logic                    flush,
    output logic [OUT_WIDTH-1:0]    d_b,
    output logic                    vld_b,
    input  logic                    rdy_b,
    input  logic                    is_done_mode_user,
    output logic [PAYLOAD_BITS-1:0] full_cnt,
    output logic [PAYLOAD_BITS-1:0] empty_cnt,
    output logic [PAYLOAD_BITS-1:0] write_cnt,
    output logic                    stall_condition
);
    localparam int DEPTH = 1 << ASIZE;
    localparam int PW    = ASIZE + 1;

    if (!width_ok_f(OUT_WIDTH, IN_WIDTH)) begin : g_bad_width
        $error("pack_queue_fifo: OUT_WIDTH must be a power-of-two multiple (>=2) of IN_WIDTH");
    end

    logic [OUT_WIDTH-1:0]    mem_q [DEPTH];
    logic [OUT_WIDTH-1:0]    wr_data;
    logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PAYLOAD_BITS-1:0] full_cnt_q, full_cnt_d, empty_cnt_q, empty_cnt_d, write_cnt_q, write_cnt_d;
    logic                    full, empty, wr_en, rd_en, accept;

    pack_queue_fifo_pack_stage #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_pack_stage (
        .clk    (clk),
        .reset  (reset),
        .d_a    (d_a),
        .vld_a  (vld_a),
        .flush  (flush),
        .full   (full),
        .rdy_a  (rdy_a),
        .accept (accept),
        .wr_en  (wr_en),
        .wr_data(wr_data)
    );

    assign empty = wptr_q == rptr_q;
    assign full  = (wptr_q[ASIZE] != rptr_q[ASIZE]) && (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
    assign vld_b = !empty;
    assign d_b   = mem_q[rptr_q[ASIZE-1:0]];
    assign rd_en = vld_b && rdy_b;

    assign full_cnt        = full_cnt_q;
    assign empty_cnt       = empty_cnt_q;
    assign write_cnt       = write_cnt_q;
    assign stall_condition = !is_done_mode_user && ((INPUT_PORT != 0) ? (rdy_b && empty) : (vld_a && !rdy_a));

    always_comb begin
        wptr_d      = wptr_q + PW'(wr_en);
        rptr_d      = rptr_q + PW'(rd_en);
        full_cnt_d  = full_cnt_q + PAYLOAD_BITS'(!is_done_mode_user && full);
        empty_cnt_d = empty_cnt_q + PAYLOAD_BITS'(!is_done_mode_user && empty);
        write_cnt_d = write_cnt_q + PAYLOAD_BITS'(!is_done_mode_user && accept);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[ASIZE-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            full_cnt_q  <= '0;
            empty_cnt_q <= '0;
            write_cnt_q <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            full_cnt_q  <= full_cnt_d;
            empty_cnt_q <= empty_cnt_d;
            write_cnt_q <= write_cnt_d;
        end
    end
endmodule

// File: tb/tb_pack_queue_fifo.sv
// tb_pack_queue_fifo: randomized scoreboard bench against a queue-based packing model
module tb_pack_queue_fifo;
    localparam int IW = 32;
    localparam int OW = 512;
    localparam int R = OW / IW;
    localparam int DEPTH = 32;

    logic clk = 1'b0, reset = 1'b1, vld_a = 1'b0, flush = 1'b0, rdy_b = 1'b0, done = 1'b0;
    logic [IW-1:0] d_a = '0;
    logic rdy_a0, vld_b0, stall0, rdy_a1, vld_b1, stall1;
    logic [OW-1:0] d_b0, d_b1;
    logic [31:0] fc0, ec0, wc0, fc1, ec1, wc1;

    int errs = 0, checks = 0;

    logic [IW-1:0] beats[$];
    logic [OW-1:0] exp_q[$];
    int occ = 0;
    bit pend_m = 1'b0;
    logic [31:0] fc_m = '0, ec_m = '0, wc_m = '0;

    always #5 clk = ~clk;

    pack_queue_fifo u_dut0 (
        .clk(clk), .reset(reset), .d_a(d_a), .vld_a(vld_a), .rdy_a(rdy_a0), .flush(flush),
        .d_b(d_b0), .vld_b(vld_b0), .rdy_b(rdy_b), .is_done_mode_user(done),
        .full_cnt(fc0), .empty_cnt(ec0), .write_cnt(wc0), .stall_condition(stall0)
    );

    pack_queue_fifo #(.INPUT_PORT(1)) u_dut1 (
        .clk(clk), .reset(reset), .d_a(d_a), .vld_a(vld_a), .rdy_a(rdy_a1), .flush(flush),
        .d_b(d_b1), .vld_b(vld_b1), .rdy_b(rdy_b), .is_done_mode_user(done),
        .full_cnt(fc1), .empty_cnt(ec1), .write_cnt(wc1), .stall_condition(stall1)
    );

    task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] pack_word();
        logic [OW-1:0] w = '0;
        foreach (beats[i]) w[i*IW +: IW] = beats[i];
        return w;
    endfunction

    // reference model: beats and whole words as queues, occupancy as a plain count
    initial forever begin
        bit fm, em, rm, acc, wr, rd;
        @(posedge clk or posedge reset);
        if (reset) begin
            beats.delete();
            exp_q.delete();
            occ = 0;
            pend_m = 1'b0;
            fc_m = '0;
            ec_m = '0;
            wc_m = '0;
        end else begin
            fm = occ == DEPTH;
            em = occ == 0;
            rm = !pend_m && (beats.size() < R - 1 || !fm);
            acc = vld_a && rm;
            rd = !em && rdy_b;
            wr = 1'b0;
            if (!done) begin
                fc_m = fc_m + 32'(fm);
                ec_m = ec_m + 32'(em);
                wc_m = wc_m + 32'(acc);
            end
            if (pend_m) begin
                if (!fm) begin
                    wr = 1'b1;
                    pend_m = 1'b0;
                end
            end else begin
                if (acc) beats.push_back(d_a);
                if (beats.size() == R) begin
                    exp_q.push_back(pack_word());
                    beats.delete();
                    wr = 1'b1;
                end else if (flush && beats.size() > 0) begin
                    exp_q.push_back(pack_word());
                    beats.delete();
                    if (fm) pend_m = 1'b1;
                    else wr = 1'b1;
                end
            end
            occ = occ + int'(wr) - int'(rd);
        end
    end

    // monitor: per-cycle status checks and scoreboard pop on every output handshake
    initial forever begin
        bit rdy_exp;
        @(negedge clk);
        rdy_exp = !reset && !pend_m && (beats.size() < R - 1 || occ < DEPTH);
        chk("rdy_a", OW'(rdy_a0), OW'(rdy_exp));
        chk("vld_b", OW'(vld_b0), OW'(occ != 0));
        chk("full_cnt", OW'(fc0), OW'(fc_m));
        chk("empty_cnt", OW'(ec0), OW'(ec_m));
        chk("write_cnt", OW'(wc0), OW'(wc_m));
        chk("stall_out_port", OW'(stall0), OW'(!done && vld_a && !rdy_exp));
        chk("stall_in_port", OW'(stall1), OW'(!done && rdy_b && occ == 0));
        if (vld_b0 && rdy_b) begin
            if (exp_q.size() == 0) chk("unexpected_word", d_b0, '0 - 1'b1 ^ d_b0);
            else chk("d_b", d_b0, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [IW-1:0] v, input bit f = 1'b0);
        int n = 0;
        bit ok;
        vld_a = 1'b1;
        d_a = v;
        flush = f;
        do begin
            ok = rdy_a0;
            step();
            n++;
        end while (!ok && n < 2000);
        flush = 1'b0;
        if (!ok) chk("beat_timeout", OW'(ok), OW'(1));
    endtask

    task automatic drain();
        int n = 0;
        vld_a = 1'b0;
        rdy_b = 1'b1;
        while (vld_b0 && n < 200) begin
            step();
            n++;
        end
        chk("drain_empty", OW'(vld_b0), OW'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [OW-1:0] w;
        step();
        step();
        chk("reset_vld_b", OW'(vld_b0), OW'(0));
        chk("reset_rdy_a", OW'(rdy_a0), OW'(0));
        chk("reset_counters", OW'({fc0, ec0, wc0}), OW'(0));
        reset = 1'b0;
        #1;
        chk("rdy_after_reset", OW'(rdy_a0), OW'(1));

        rdy_b = 1'b1;
        for (int i = 0; i < R; i++) beat(IW'(i));
        vld_a = 1'b0;
        chk("word0_vld", OW'(vld_b0), OW'(1));
        chk("word0_slot0", OW'(d_b0[31:0]), OW'(0));
        chk("word0_slot15", OW'(d_b0[511:480]), OW'(15));
        chk("word0_wcnt", OW'(wc0), OW'(16));
        step();
        chk("word0_emptied", OW'(vld_b0), OW'(0));

        rdy_b = 1'b0;
        for (int i = 0; i < DEPTH * R + R - 1; i++) beat($urandom);
        vld_a = 1'b1;
        d_a = 32'hdead_beef;
        step();
        step();
        chk("full_stall_rdy", OW'(rdy_a0), OW'(0));
        chk("full_stall_flag", OW'(stall0), OW'(1));
        rdy_b = 1'b1;
        beat(32'hdead_beef);
        drain();

        beat(32'haaaa_0001);
        beat(32'hbbbb_0002);
        beat(32'hcccc_0003);
        vld_a = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        w = '0;
        w[95:0] = {32'hcccc_0003, 32'hbbbb_0002, 32'haaaa_0001};
        chk("flush_vld", OW'(vld_b0), OW'(1));
        chk("flush_word", d_b0, w);
        for (int i = 0; i < R; i++) beat(IW'(100 + i));
        drain();

        rdy_b = 1'b0;
        for (int i = 0; i < R - 1; i++) beat($urandom);
        beat(32'h1234_5678, 1'b1);
        vld_a = 1'b0;
        step();
        chk("flush_last_one_word", OW'(vld_b0), OW'(1));
        rdy_b = 1'b1;
        step();
        chk("flush_last_no_extra", OW'(vld_b0), OW'(0));

        rdy_b = 1'b0;
        for (int i = 0; i < DEPTH * R + 4; i++) beat($urandom);
        vld_a = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        step();
        chk("pend_blocks_rdy", OW'(rdy_a0), OW'(0));
        rdy_b = 1'b1;
        step();
        rdy_b = 1'b0;
        chk("pend_still_blocks", OW'(rdy_a0), OW'(0));
        step();
        chk("pend_released", OW'(rdy_a0), OW'(1));
        drain();

        for (int i = 0; i < 7; i++) beat($urandom);
        vld_a = 1'b0;
        reset = 1'b1;
        done = 1'b1;
        #1;
        chk("midword_reset_vld", OW'(vld_b0), OW'(0));
        chk("midword_reset_wcnt", OW'(wc0), OW'(0));
        step();
        reset = 1'b0;
        for (int c = 0; c < 60; c++) begin
            vld_a = $urandom_range(1);
            d_a = $urandom;
            rdy_b = $urandom_range(1);
            step();
        end
        chk("done_hold_counters", OW'({fc0, ec0, wc0}), OW'(0));
        chk("done_no_stall", OW'({stall0, stall1}), OW'(0));
        drain();
        done = 1'b0;
        #1;
        chk("in_port_stall", OW'(stall1), OW'(1));
        for (int i = 0; i < R; i++) beat(IW'(200 + i));
        drain();

        for (int c = 0; c < 2000; c++) begin
            vld_a = $urandom_range(3) != 0;
            d_a = $urandom;
            flush = $urandom_range(15) == 0;
            rdy_b = (c % 1000 < 700) ? 1'b0 : ($urandom_range(2) != 0);
            done = (c % 700) > 600;
            step();
        end
        flush = 1'b0;
        done = 1'b0;
        drain();
        chk("scoreboard_empty", OW'(exp_q.size()), OW'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
